// File: rtl/cg_pkg.sv
// Shared constants and helpers for the CG result write-back block.
// Derived constants follow the default geometry; the top recomputes them from its own parameters.
package cg_pkg;

    localparam int NUMBER_OF_CLUSTERS              = 40;
    localparam int NUMBER_OF_EQUATIONS_PER_CLUSTER = 19;
    localparam int ELEMENT_WIDTH                   = 32;
    localparam int NO_OF_UNITS                     = 8;
    localparam int MEMORIES_ADDRESS_WIDTH          = 20;

    function automatic int calc_beats(input int n_total, input int units);
        return (n_total + units - 1) / units;
    endfunction

    function automatic int calc_rem(input int n_total, input int units);
        return n_total % units;
    endfunction

    function automatic int calc_cnt_w(input int beats);
        return $clog2(beats) + 1;
    endfunction

    localparam int N_TOTAL    = NUMBER_OF_CLUSTERS * NUMBER_OF_EQUATIONS_PER_CLUSTER;
    localparam int BEATS      = calc_beats(N_TOTAL, NO_OF_UNITS);
    localparam int REM        = calc_rem(N_TOTAL, NO_OF_UNITS);
    localparam int BEAT_CNT_W = calc_cnt_w(BEATS);
    localparam int DATA_W     = NO_OF_UNITS * ELEMENT_WIDTH;

    typedef enum logic {
        CH_RUN  = 1'b0,
        CH_DONE = 1'b1
    } ch_state_t;

endpackage

// File: rtl/cg_wb_channel.sv
// One result channel: beat counter, lane mask, done/overflow tracking and a registered memory write.
// Optional running XOR checksum of written lanes when CG_WB_CHECKSUM_EN is defined.
module cg_wb_channel
    import cg_pkg::*;
#(
    parameter int units         = NO_OF_UNITS,
    parameter int element_width = ELEMENT_WIDTH,
    parameter int beats         = BEATS,
    parameter int rem           = REM,
    parameter int cnt_w         = BEAT_CNT_W,
    parameter int addr_w        = MEMORIES_ADDRESS_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             auto_clear,
    input  logic                             we,
    input  logic [units*element_width-1:0]   data,
    output logic                             mem_we,
    output logic [addr_w-1:0]                mem_addr,
    output logic [units*element_width-1:0]   mem_data,
    output logic [units-1:0]                 mem_mask,
    output logic                             done,
    output logic                             overflow,
    output logic [element_width-1:0]         checksum
);

    localparam logic [cnt_w-1:0] LAST_BEAT = cnt_w'(beats - 1);

    ch_state_t          state;
    logic [cnt_w-1:0]   cnt;
    logic [cnt_w-1:0]   beat_idx;
    logic               accept;
    logic [units-1:0]   beat_mask;

    // A strobe coinciding with start restarts the vector and lands as beat 0.
    always_comb begin
        beat_idx  = start ? '0 : cnt;
        accept    = we && (start || state == CH_RUN);
        beat_mask = '1;
        if (beat_idx == LAST_BEAT && rem != 0) begin
            for (int i = 0; i < units; i++) begin
                beat_mask[i] = (i < rem);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CH_RUN;
            cnt      <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_mask <= '0;
            overflow <= 1'b0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr <= addr_w'(beat_idx);
                mem_data <= data;
                mem_mask <= beat_mask;
                cnt      <= beat_idx + 1'b1;
                state    <= (beat_idx == LAST_BEAT) ? CH_DONE : CH_RUN;
            end else if (start || auto_clear) begin
                cnt   <= '0;
                state <= CH_RUN;
            end
            // auto_clear only fires while done, so a strobe then is also an overflow
            if (start) begin
                overflow <= 1'b0;
            end else if (we && state == CH_DONE) begin
                overflow <= 1'b1;
            end
        end
    end

    assign done = (state == CH_DONE);

`ifdef CG_WB_CHECKSUM_EN
    logic [element_width-1:0] lane_xor;
    logic [element_width-1:0] csum;

    always_comb begin
        lane_xor = '0;
        for (int i = 0; i < units; i++) begin
            if (beat_mask[i]) begin
                lane_xor = lane_xor ^ data[i*element_width +: element_width];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (accept) begin
            csum <= (start ? '0 : csum) ^ lane_xor;
        end else if (start || auto_clear) begin
            csum <= '0;
        end
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: rtl/cg_result_writeback.sv
// Write-back of P/R/X result beats into the vector memories, with iteration completion tracking.
// CG_WB_CHECKSUM_EN enables per-channel XOR checksums; otherwise checksum_* are 0.
module cg_result_writeback
    import cg_pkg::*;
#(
    parameter int number_of_clusters              = NUMBER_OF_CLUSTERS,
    parameter int number_of_equations_per_cluster = NUMBER_OF_EQUATIONS_PER_CLUSTER,
    parameter int element_width                   = ELEMENT_WIDTH,
    parameter int no_of_units                     = NO_OF_UNITS,
    parameter int memories_address_width          = MEMORIES_ADDRESS_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   p_we,
    input  logic                                   r_we,
    input  logic                                   x_we,
    input  logic [no_of_units*element_width-1:0]   p_data,
    input  logic [no_of_units*element_width-1:0]   r_data,
    input  logic [no_of_units*element_width-1:0]   x_data,
    output logic                                   memoryP_we,
    output logic                                   memoryR_we,
    output logic                                   memoryX_we,
    output logic [memories_address_width-1:0]      memoryP_write_address,
    output logic [memories_address_width-1:0]      memoryR_write_address,
    output logic [memories_address_width-1:0]      memoryX_write_address,
    output logic [no_of_units*element_width-1:0]   memoryP_input,
    output logic [no_of_units*element_width-1:0]   memoryR_input,
    output logic [no_of_units*element_width-1:0]   memoryX_input,
    output logic [no_of_units-1:0]                 memoryP_mask,
    output logic [no_of_units-1:0]                 memoryR_mask,
    output logic [no_of_units-1:0]                 memoryX_mask,
    output logic                                   p_done,
    output logic                                   r_done,
    output logic                                   x_done,
    output logic                                   iteration_done,
    output logic [31:0]                            iteration_count,
    output logic                                   overflow_err,
    output logic [element_width-1:0]               checksum_p,
    output logic [element_width-1:0]               checksum_r,
    output logic [element_width-1:0]               checksum_x
);

    localparam int n_total = number_of_clusters * number_of_equations_per_cluster;
    localparam int beats   = calc_beats(n_total, no_of_units);
    localparam int rem     = calc_rem(n_total, no_of_units);
    localparam int cnt_w   = calc_cnt_w(beats);

    logic all_done;
    logic p_ovf;
    logic r_ovf;
    logic x_ovf;

    // The done flags are registered, so this is a clean one-cycle pulse: the
    // channels auto-clear on the same edge that bumps iteration_count.
    assign all_done       = p_done & r_done & x_done;
    assign iteration_done = all_done;
    assign overflow_err   = p_ovf | r_ovf | x_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iteration_count <= '0;
        end else if (all_done) begin
            iteration_count <= iteration_count + 32'd1;
        end
    end

    cg_wb_channel #(
        .units(no_of_units), .element_width(element_width), .beats(beats),
        .rem(rem), .cnt_w(cnt_w), .addr_w(memories_address_width)
    ) u_p (
        .clk(clk), .reset(reset), .start(start), .auto_clear(all_done),
        .we(p_we), .data(p_data),
        .mem_we(memoryP_we), .mem_addr(memoryP_write_address),
        .mem_data(memoryP_input), .mem_mask(memoryP_mask),
        .done(p_done), .overflow(p_ovf), .checksum(checksum_p)
    );

    cg_wb_channel #(
        .units(no_of_units), .element_width(element_width), .beats(beats),
        .rem(rem), .cnt_w(cnt_w), .addr_w(memories_address_width)
    ) u_r (
        .clk(clk), .reset(reset), .start(start), .auto_clear(all_done),
        .we(r_we), .data(r_data),
        .mem_we(memoryR_we), .mem_addr(memoryR_write_address),
        .mem_data(memoryR_input), .mem_mask(memoryR_mask),
        .done(r_done), .overflow(r_ovf), .checksum(checksum_r)
    );

    cg_wb_channel #(
        .units(no_of_units), .element_width(element_width), .beats(beats),
        .rem(rem), .cnt_w(cnt_w), .addr_w(memories_address_width)
    ) u_x (
        .clk(clk), .reset(reset), .start(start), .auto_clear(all_done),
        .we(x_we), .data(x_data),
        .mem_we(memoryX_we), .mem_addr(memoryX_write_address),
        .mem_data(memoryX_input), .mem_mask(memoryX_mask),
        .done(x_done), .overflow(x_ovf), .checksum(checksum_x)
    );

endmodule

// File: tb/tb_cg_result_writeback.sv
// Directed bench for cg_result_writeback: default geometry (760 elements) plus a 761-element instance.
// Write expectations are queued on drive and popped when the memory write strobes appear.
module tb_cg_result_writeback;

    localparam int DW = 256;
    localparam int QW = 32 + 20 + 8 + DW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic p_we = 1'b0, r_we = 1'b0, x_we = 1'b0, b_p_we = 1'b0;
    logic [DW-1:0] p_data = '0, r_data = '0, x_data = '0, b_p_data = '0;
    logic zero_we = 1'b0;
    logic [DW-1:0] zero_data = '0;

    logic mp_we, mr_we, mx_we;
    logic [19:0] mp_addr, mr_addr, mx_addr;
    logic [DW-1:0] mp_in, mr_in, mx_in;
    logic [7:0] mp_mask, mr_mask, mx_mask;
    logic p_done, r_done, x_done, iteration_done, overflow_err;
    logic [31:0] iteration_count, checksum_p, checksum_r, checksum_x;

    logic bp_we, br_we, bx_we;
    logic [19:0] bp_addr, br_addr, bx_addr;
    logic [DW-1:0] bp_in, br_in, bx_in;
    logic [7:0] bp_mask, br_mask, bx_mask;
    logic b_p_done, b_r_done, b_x_done, b_iter_done, b_ovf;
    logic [31:0] b_iter_cnt, b_cs_p, b_cs_r, b_cs_x;

    cg_result_writeback dut (
        .clk(clk), .reset(reset), .start(start),
        .p_we(p_we), .r_we(r_we), .x_we(x_we),
        .p_data(p_data), .r_data(r_data), .x_data(x_data),
        .memoryP_we(mp_we), .memoryR_we(mr_we), .memoryX_we(mx_we),
        .memoryP_write_address(mp_addr), .memoryR_write_address(mr_addr), .memoryX_write_address(mx_addr),
        .memoryP_input(mp_in), .memoryR_input(mr_in), .memoryX_input(mx_in),
        .memoryP_mask(mp_mask), .memoryR_mask(mr_mask), .memoryX_mask(mx_mask),
        .p_done(p_done), .r_done(r_done), .x_done(x_done),
        .iteration_done(iteration_done), .iteration_count(iteration_count),
        .overflow_err(overflow_err),
        .checksum_p(checksum_p), .checksum_r(checksum_r), .checksum_x(checksum_x)
    );

    cg_result_writeback #(
        .number_of_clusters(1), .number_of_equations_per_cluster(761)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start),
        .p_we(b_p_we), .r_we(zero_we), .x_we(zero_we),
        .p_data(b_p_data), .r_data(zero_data), .x_data(zero_data),
        .memoryP_we(bp_we), .memoryR_we(br_we), .memoryX_we(bx_we),
        .memoryP_write_address(bp_addr), .memoryR_write_address(br_addr), .memoryX_write_address(bx_addr),
        .memoryP_input(bp_in), .memoryR_input(br_in), .memoryX_input(bx_in),
        .memoryP_mask(bp_mask), .memoryR_mask(br_mask), .memoryX_mask(bx_mask),
        .p_done(b_p_done), .r_done(b_r_done), .x_done(b_x_done),
        .iteration_done(b_iter_done), .iteration_count(b_iter_cnt),
        .overflow_err(b_ovf),
        .checksum_p(b_cs_p), .checksum_r(b_cs_r), .checksum_x(b_cs_x)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [QW-1:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];

    int          mcnt[4];
    bit          mdone[4];
    logic [31:0] mcs[4];
    bit          movf[2];
    logic [31:0] miter;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input int ch, input logic [QW-1:0] v);
        case (ch)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            2: exp_q2.push_back(v);
            default: exp_q3.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int ch);
        case (ch)
            0: return exp_q0.size();
            1: return exp_q1.size();
            2: return exp_q2.size();
            default: return exp_q3.size();
        endcase
    endfunction

    function automatic logic [QW-1:0] pop_exp(input int ch);
        case (ch)
            0: return exp_q0.pop_front();
            1: return exp_q1.pop_front();
            2: return exp_q2.pop_front();
            default: return exp_q3.pop_front();
        endcase
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [31:0] exp_cs(input int ch);
`ifdef CG_WB_CHECKSUM_EN
        return mcs[ch];
`else
        return (ch < 0) ? mcs[0] : 32'h0;
`endif
    endfunction

    task automatic mon(input int ch, input string tag, input logic we, input logic [19:0] a,
                       input logic [DW-1:0] d, input logic [7:0] m);
        logic [QW-1:0] e;
        if (we !== 1'b0) begin
            checks++;
            assert (qsize(ch) > 0) else begin
                errors++;
                $error("FAIL %s_unexpected_write: observed write at address %0h, required no write", tag, a);
            end
            if (qsize(ch) > 0) begin
                e = pop_exp(ch);
                check({tag, "_latency_cycle"}, cyc, e[QW-1 -: 32]);
                check({tag, "_addr"}, a, e[DW+27 -: 20]);
                check({tag, "_mask"}, m, e[DW+7 -: 8]);
                check({tag, "_data"}, d, e[DW-1:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, "memP", mp_we, mp_addr, mp_in, mp_mask);
        mon(1, "memR", mr_we, mr_addr, mr_in, mr_mask);
        mon(2, "memX", mx_we, mx_addr, mx_in, mx_mask);
        mon(3, "memP761", bp_we, bp_addr, bp_in, bp_mask);
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        start = 1'b0;
        p_we = 1'b0; r_we = 1'b0; x_we = 1'b0; b_p_we = 1'b0;
    endtask

    task automatic check_state(input bit all_main);
        check("p_done", p_done, mdone[0]);
        check("r_done", r_done, mdone[1]);
        check("x_done", x_done, mdone[2]);
        check("overflow_err", overflow_err, movf[0]);
        check("iteration_done", iteration_done, all_main);
        check("iteration_count", iteration_count, miter);
        check("checksum_p", checksum_p, exp_cs(0));
        check("checksum_r", checksum_r, exp_cs(1));
        check("checksum_x", checksum_x, exp_cs(2));
        check("p761_done", b_p_done, mdone[3]);
        check("p761_overflow", b_ovf, movf[1]);
        check("p761_checksum", b_cs_p, exp_cs(3));
        check("p761_iteration_done", b_iter_done, 1'b0);
    endtask

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic drive(input bit pw, input bit rw, input bit xw, input bit bw, input bit st);
        logic [DW-1:0] d[4];
        bit we[4];
        bit all_main;
        int bt, nb, nt;
        logic [7:0] m;
        logic [31:0] lx;
        all_main = mdone[0] && mdone[1] && mdone[2];
        check_state(all_main);
        we = '{pw, rw, xw, bw};
        for (int ch = 0; ch < 4; ch++) d[ch] = rand_data();
        p_data = d[0]; r_data = d[1]; x_data = d[2]; b_p_data = d[3];
        p_we = pw; r_we = rw; x_we = xw; b_p_we = bw; start = st;
        if (st) movf = '{1'b0, 1'b0};
        for (int ch = 0; ch < 4; ch++) begin
            nt = (ch == 3) ? 761 : 760;
            nb = (ch == 3) ? 96 : 95;
            if (we[ch] && (st || !mdone[ch])) begin
                bt = st ? 0 : mcnt[ch];
                m = 8'hFF;
                if (bt == nb - 1 && (nt % 8) != 0) m = 8'((1 << (nt % 8)) - 1);
                lx = 32'h0;
                for (int l = 0; l < 8; l++) if (m[l]) lx = lx ^ d[ch][l*32 +: 32];
                mcs[ch] = (st ? 32'h0 : mcs[ch]) ^ lx;
                push_exp(ch, {32'(cyc + 1), 20'(bt), m, d[ch]});
                mcnt[ch] = bt + 1;
                mdone[ch] = (bt == nb - 1);
            end else begin
                if (we[ch]) movf[(ch == 3) ? 1 : 0] = 1'b1;
                if (st || (ch < 3 && all_main)) begin
                    mcnt[ch] = 0;
                    mdone[ch] = 1'b0;
                    mcs[ch] = 32'h0;
                end
            end
        end
        if (all_main) miter = miter + 32'd1;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete(); exp_q3.delete();
        for (int ch = 0; ch < 4; ch++) begin
            mcnt[ch] = 0; mdone[ch] = 1'b0; mcs[ch] = 32'h0;
        end
        movf = '{1'b0, 1'b0};
        miter = 32'h0;
        check("rst_memP_we", {mp_we, mr_we, mx_we, bp_we}, 4'h0);
        check("rst_addrs", {mp_addr, mr_addr, mx_addr}, 60'h0);
        check("rst_memP_input", mp_in, 256'h0);
        check("rst_memR_input", mr_in, 256'h0);
        check("rst_memX_input", mx_in, 256'h0);
        check("rst_masks", {mp_mask, mr_mask, mx_mask}, 24'h0);
        check("rst_done", {p_done, r_done, x_done}, 3'h0);
        check("rst_iteration_done", iteration_done, 1'b0);
        check("rst_iteration_count", iteration_count, 32'h0);
        check("rst_overflow_err", overflow_err, 1'b0);
        check("rst_checksums", {checksum_p, checksum_r, checksum_x}, 96'h0);
        reset = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        miter = 32'h0;
        for (int ch = 0; ch < 4; ch++) begin
            mcnt[ch] = 0; mdone[ch] = 1'b0; mcs[ch] = 32'h0;
        end
        movf = '{1'b0, 1'b0};
        #1;
        apply_reset();

        // 95 back-to-back P beats
        for (int i = 0; i < 95; i++) drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // P, R, X in lockstep; a P strobe lands in the all-done cycle
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 95; i++) drive(1, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);

        // X finishes first, then an extra X beat overflows and is dropped
        for (int i = 0; i < 95; i++)
            drive((i < 90) ? 1'($urandom_range(0, 1)) : 1'b0,
                  (i < 90) ? 1'($urandom_range(0, 1)) : 1'b0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);

        // start together with the R beat at index 10
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // reset arrives while R beat 40 is strobed
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) drive(0, 1, 0, 0, 0);
        r_we = 1'b1;
        r_data = rand_data();
        apply_reset();
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // 761-element instance: 96 beats, last one single-lane
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 96; i++) drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        for (int ch = 0; ch < 4; ch++) check($sformatf("pending_writes_ch%0d", ch), qsize(ch), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
